// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the two-requester "101" detector scheduler.
// Scheduler FSM states, detector encodings and default widths.
package seq_det_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    REPORT
  } state_e;

  typedef enum logic [1:0] {
    S_IDLE1,
    S_GOT1,
    S_GOT10
  } det_e;

endpackage

// File: rtl/seq_det_sched_if.sv
// Request and result handshake bundle for seq_det_sched.
// master drives requests and consumes results; slave is the scheduler.
interface seq_det_sched_if
  import seq_det_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req_data0;
  logic [DATA_W-1:0] req_data1;
  logic              res_valid;
  logic              res_ready;
  logic              res_id;
  logic [CNT_W-1:0]  res_count;
  logic              res_hit;

  modport master (
    output req_valid, req_data0, req_data1, res_ready,
    input  req_ready, res_valid, res_id, res_count, res_hit
  );

  modport slave (
    input  req_valid, req_data0, req_data1, res_ready,
    output req_ready, res_valid, res_id, res_count, res_hit
  );

endinterface

// File: rtl/seq101_det_core.sv
// Overlapping "101" serial detector, Mealy match output.
// clr returns to the initial state so frames never share history.
module seq101_det_core
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic match
);

  det_e st_q, st_d;

  always_comb begin
    st_d  = st_q;
    match = 1'b0;
    if (clr) begin
      st_d = S_IDLE1;
    end else if (en) begin
      unique case (st_q)
        S_IDLE1: st_d = bit_in ? S_GOT1 : S_IDLE1;
        S_GOT1:  st_d = bit_in ? S_GOT1 : S_GOT10;
        S_GOT10: begin
          // the matching 1 starts the next pattern
          st_d  = bit_in ? S_GOT1 : S_IDLE1;
          match = bit_in;
        end
        default: st_d = S_IDLE1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) st_q <= S_IDLE1;
    else          st_q <= st_d;
  end

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler serializing two requesters' words into one
// "101" detector and returning {id, match count} per frame.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           reset_n,
  seq_det_sched_if.slave bus,
  output logic           busy,
  output logic           ser_en,
  output logic           ser_bit
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
  logic              id_q, id_d;
  logic              rr_q, rr_d;
  logic              res_id_q, res_id_d;
  logic              res_hit_q, res_hit_d;
  logic              any_v, gnt, shifting, match;

  assign any_v    = |bus.req_valid;
  // on a tie the requester that did not win last time goes
  assign gnt      = (&bus.req_valid) ? ~rr_q : bus.req_valid[1];
  assign shifting = (state_q == SHIFT);
  assign cnt_inc  = cnt_q + {{(CNT_W-1){1'b0}}, match};

  seq101_det_core u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_q == IDLE),
    .en      (shifting),
    .bit_in  (shift_q[DATA_W-1]),
    .match   (match)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    rr_d      = rr_q;
    res_id_d  = res_id_q;
    res_cnt_d = res_cnt_q;
    res_hit_d = res_hit_q;
    unique case (state_q)
      IDLE: begin
        if (any_v) begin
          shift_d = gnt ? bus.req_data1 : bus.req_data0;
          id_d    = gnt;
          rr_d    = gnt;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = shift_q << 1;
        idx_d   = idx_q + IDX_W'(1);
        cnt_d   = cnt_inc;
        if (idx_q == LAST) begin
          res_id_d  = id_q;
          res_cnt_d = cnt_inc;
          res_hit_d = (cnt_inc != '0);
          state_d   = REPORT;
        end
      end
      REPORT: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      rr_q      <= 1'b1;
      res_id_q  <= 1'b0;
      res_cnt_q <= '0;
      res_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      rr_q      <= rr_d;
      res_id_q  <= res_id_d;
      res_cnt_q <= res_cnt_d;
      res_hit_q <= res_hit_d;
    end
  end

  assign bus.req_ready = (reset_n && state_q == IDLE && any_v)
                         ? {gnt, ~gnt} : 2'b00;
  assign bus.res_valid = (state_q == REPORT);
  assign bus.res_id    = res_id_q;
  assign bus.res_count = res_cnt_q;
  assign bus.res_hit   = res_hit_q;
  assign busy          = (state_q != IDLE);
  assign ser_en        = shifting;
  assign ser_bit       = shifting & shift_q[DATA_W-1];

endmodule
